// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
//               It provides the controller state encoding, the PC-source
//               select codes and the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        WAIT  = 2'b01,
        REDIR = 2'b10
    } ctrl_state_e;

    // PC source select codes
    localparam logic [1:0] PCSEL_SEQ = 2'b00;   // PC + 4
    localparam logic [1:0] PCSEL_BR  = 2'b01;   // branch target
    localparam logic [1:0] PCSEL_J   = 2'b10;   // jump target

    // Register 0 is hard-wired to zero, so writes to it never create a hazard
    localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard comparator. It flags when the
//               instruction in EX is a load whose destination is read by the
//               instruction in ID.
// Ports       : ex_rw_i, ex_memtoreg_i, ex_regwr_i  - EX destination/control
//               id_rs_i, id_rt_i, id_uses_rt_i     - ID source operands
//               lduse_o                            - load-use hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rw_i,
    input  logic       ex_memtoreg_i,
    input  logic       ex_regwr_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       lduse_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit  = (ex_rw_i == id_rs_i);
    // rt only matters for instructions that actually read it
    assign rt_hit  = id_uses_rt_i && (ex_rw_i == id_rt_i);
    assign lduse_o = ex_memtoreg_i && ex_regwr_i && (ex_rw_i != REG_ZERO)
                     && (rs_hit || rt_hit);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central hazard and sequencing controller for the 5-stage
//               pipeline. Generates stage-register enables/flushes, selects
//               the PC source and freezes the pipeline on data-memory waits.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               id_*, ex_*, mem_*          - pipeline hazard/resolution info
//               dmem_ready                 - data memory completes this cycle
//               pc_we, pc_sel              - PC update enable and source
//               *_we, *_flush              - stage-register enables / bubbles
//               dmem_req                   - data-memory access in progress
//               stall_cnt, flush_cnt       - saturating event counters
//               mem_timeout                - sticky memory-wait timeout fault
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rw,
    input  logic             ex_memtoreg,
    input  logic             ex_regwr,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_jump,
    input  logic             mem_memwr,
    input  logic             mem_memtoreg,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ifid_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             dmem_req,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int                WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    ctrl_state_e       state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic redirect;
    logic memop;
    logic lduse;
    logic stall_inc;
    logic flush_inc;

    assign redirect = mem_jump | (mem_branch & mem_zero);
    assign memop    = mem_memwr | mem_memtoreg;

    hazard_detect u_hazard_detect (
        .ex_rw_i       (ex_rw),
        .ex_memtoreg_i (ex_memtoreg),
        .ex_regwr_i    (ex_regwr),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .lduse_o       (lduse)
    );

    always_comb begin
        // Normal flow defaults
        state_d     = state_q;
        wait_d      = wait_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_we       = 1'b1;
        pc_sel      = PCSEL_SEQ;
        ifid_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        dmem_req    = memop;

        case (state_q)
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    wait_d  = '0;
                    state_d = RUN;
                end else begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    exmem_we    = 1'b0;
                    memwb_flush = 1'b1;
                    stall_inc   = 1'b1;
                    if (wait_q != WAIT_LIMIT) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            default: begin  // RUN and REDIR
                if (redirect) begin
                    // Any memop alongside a redirect is dropped for this cycle
                    pc_sel      = mem_jump ? PCSEL_J : PCSEL_BR;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    dmem_req    = 1'b0;
                    flush_inc   = 1'b1;
                    state_d     = REDIR;
                end else if (memop && !dmem_ready) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    exmem_we    = 1'b0;
                    memwb_flush = 1'b1;
                    dmem_req    = 1'b1;
                    stall_inc   = 1'b1;
                    state_d     = WAIT;
                end else if (lduse && (state_q == RUN)) begin
                    // In REDIR the ID stage holds a bubble, so lduse is stale
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                    state_d    = RUN;
                end else begin
                    state_d = RUN;
                end
            end
        endcase

        // Hold the whole pipeline in bubbles while reset is asserted
        if (!rst_n) begin
            pc_we       = 1'b0;
            pc_sel      = PCSEL_SEQ;
            ifid_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            dmem_req    = 1'b0;
        end
    end

    // Saturating event counters and sticky timeout
    always_comb begin
        stall_d   = stall_q;
        flush_d   = flush_q;
        timeout_d = timeout_q | (wait_d == WAIT_LIMIT);
        if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            stall_q   <= '0;
            flush_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign mem_timeout = timeout_q;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipeline CPU. It computes every stage-register enable and flush, selects the PC source, and freezes the pipeline while data memory is busy. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. Its inputs are the rs/rt fields decoded in ID and the control bits already carried by the ID/EX and EX/MEM registers.

## Interface
- `CNT_W`, 16: width of the saturating stall and flush event counters.
- `MAX_WAIT`, 15: number of consecutive data-memory wait cycles allowed before the timeout fault.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in 5 each: source registers of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt.
- `ex_rw` in 5, `ex_memtoreg` in 1, `ex_regwr` in 1: destination and control of the instruction in EX.
- `mem_branch`, `mem_zero`, `mem_jump` in 1 each: branch and jump resolution of the instruction in MEM.
- `mem_memwr`, `mem_memtoreg` in 1 each: the instruction in MEM stores or loads.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_we` out 1: PC update enable.
- `pc_sel` out 2: PC source. 00 = PC+4, 01 = branch target, 10 = jump target.
- `ifid_we`, `exmem_we`, `memwb_we` out 1 each: stage-register enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1 each: load a bubble (all control bits 0) into that register.
- `dmem_req` out 1: a data-memory access is in progress.
- `stall_cnt`, `flush_cnt` out CNT_W each: saturating event counters.
- `mem_timeout` out 1: sticky fault flag, cleared only by reset.

## Operation
- States: RUN, WAIT, REDIR. All outputs are combinational from the current state and inputs.
- redirect = `mem_jump` | (`mem_branch` & `mem_zero`).
- memop = `mem_memwr` | `mem_memtoreg`.
- lduse = `ex_memtoreg` & `ex_regwr` & (`ex_rw` != 0) & (`ex_rw` == `id_rs` | (`id_uses_rt` & `ex_rw` == `id_rt`)).
- Priority in RUN and REDIR: redirect, then memop & !`dmem_ready`, then lduse, then normal flow.
- Redirect:
  - `pc_sel` = 10 if `mem_jump`, else 01; `pc_we` = 1.
  - `ifid_flush`, `idex_flush` and `exmem_flush` = 1; all enables = 1.
  - Next state REDIR; `flush_cnt` += 1.
- Memory wait:
  - `dmem_req` = 1; `pc_we`, `ifid_we` and `exmem_we` = 0; `memwb_flush` = 1.
  - Next state WAIT; `stall_cnt` += 1.
- Load-use stall:
  - `pc_we` and `ifid_we` = 0; `idex_flush` = 1; EX/MEM and MEM/WB advance.
  - `stall_cnt` += 1; state unchanged.
- Normal flow: all enables = 1, all flushes = 0, `pc_sel` = 00; `dmem_req` = memop.
- WAIT state:
  - Freeze outputs identical to the memory-wait case; each cycle `stall_cnt` += 1 and the wait counter += 1.
  - On `dmem_ready` = 1 in WAIT: normal-flow outputs with `dmem_req` = 1, clear the wait counter, next state RUN.
- Timeout: when the wait counter reaches MAX_WAIT, set `mem_timeout` = 1. The controller stays in WAIT, and the wait counter saturates at MAX_WAIT.
- REDIR lasts exactly one cycle. lduse is ignored because ID holds a bubble; redirect and memop are still evaluated. Next state is RUN unless the cycle enters WAIT or REDIR.
- `pc_sel` = 00 in every case except redirect.
- Counters saturate at 2^CNT_W − 1 and never wrap.
- Simultaneous redirect and memop cannot come from legal code. If it occurs, redirect wins and memop is ignored for that cycle.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State = RUN; `stall_cnt`, `flush_cnt`, wait counter and `mem_timeout` = 0.
  - While `rst_n` is low: all `*_we` = 0, all `*_flush` = 1, `pc_we` = 0, `pc_sel` = 00, `dmem_req` = 0.
- A reset asserted mid-wait or mid-redirect aborts immediately. The first cycle after release is RUN with normal flow.
- Control outputs have zero latency from inputs. State, counters and `mem_timeout` update on the next rising edge.
- Pipeline registers sample on the falling edge, so outputs must settle within the high phase of `clk`.
- A load-use stall lasts exactly one cycle per hazard. A redirect costs exactly three bubbles. A memory wait of N not-ready cycles adds N stall cycles.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - state enum (RUN, WAIT, REDIR);
  - `pc_sel` encodings (PCSEL_SEQ, PCSEL_BR, PCSEL_J);
  - register-0 constant.
- One natural sub-module, `hazard_detect`: the combinational lduse comparator.
- The FSM, counters and output decode stay in the top module.

## Test plan
- `ex_memtoreg` = 1, `ex_regwr` = 1, `ex_rw` = 8, `id_rs` = 8 for one cycle -> `pc_we` = 0, `ifid_we` = 0, `idex_flush` = 1 for exactly 1 cycle; `stall_cnt` = 1.
- Same as above but `ex_rw` = 0, or `id_rt` = 8 with `id_uses_rt` = 0 -> no stall.
- `mem_branch` = 1, `mem_zero` = 1 -> `pc_sel` = 01, three flushes asserted for 1 cycle; REDIR masks an lduse the next cycle; `flush_cnt` = 1.
- `mem_jump` = 1 together with an active lduse -> `pc_sel` = 10, no stall.
- `mem_memtoreg` = 1, `dmem_ready` low 3 cycles then high -> 3 freeze cycles with `memwb_flush` = 1, 4th cycle advances; `stall_cnt` = 3.
- `dmem_ready` held low for 20 cycles with MAX_WAIT = 15 -> `mem_timeout` rises after the 15th wait cycle. Pulsing `rst_n` low mid-wait -> state RUN, counters 0, `mem_timeout` 0.
